// File: rtl/gcd_run_ctrl.sv
// Job sequencer for the rv32i GCD program: validates and latches operands, clears and launches
// the CPU, filters the CPU result for stability and holds the outcome with busy/done/err status.
module gcd_run_ctrl #(
   parameter int unsigned CLR_CYCLES     = 4,
   parameter int unsigned STABLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_req,
   input  logic [6:0]  op_a,
   input  logic [6:0]  op_b,
   input  logic [31:0] cpu_result,
   output logic        cpu_clr,
   output logic        cpu_start,
   output logic [31:0] cpu_a,
   output logic [31:0] cpu_b,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic [6:0]  result
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);
   localparam logic [3:0] STABLE_VAL = 4'(STABLE_CYCLES);
   // FAIL is entered TIMEOUT_CYCLES cycles after the cpu_start cycle (launch cycle included).
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 2);

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_OPERAND = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      StIdle, StClear, StLaunch, StWait, StDone, StFail
   } state_e;

   state_e state_q, state_d;

   logic [3:0]    clr_cnt_q;
   logic [TW-1:0] wait_cnt_q;
   logic [3:0]    stab_cnt_q, stab_cnt_d;
   logic [31:0]   prev_q;
   logic [31:0]   cpu_a_q, cpu_b_q;
   logic          done_q;
   logic [1:0]    err_q;
   logic [6:0]    result_q;

   logic accept, ops_bad, stable_hit, timeout_hit, range_bad;

   always_comb begin
      accept  = start_req && (state_q == StIdle || state_q == StDone || state_q == StFail);
      ops_bad = (op_a == 7'd0) || (op_b == 7'd0) || (op_a > 7'd99) || (op_b > 7'd99);

      // Run length of identical non-zero samples, including the current one.
      if (cpu_result == 32'd0) begin
         stab_cnt_d = 4'd0;
      end else if (cpu_result == prev_q) begin
         stab_cnt_d = stab_cnt_q + 4'd1;
      end else begin
         stab_cnt_d = 4'd1;
      end

      stable_hit  = (stab_cnt_d == STABLE_VAL);
      timeout_hit = (wait_cnt_q == TIMEOUT_LAST);
      range_bad   = (cpu_result > 32'd99);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone, StFail: begin
            if (accept) begin
               state_d = ops_bad ? StFail : StClear;
            end
         end
         StClear: begin
            if (clr_cnt_q == CLR_LAST) begin
               state_d = StLaunch;
            end
         end
         StLaunch: state_d = StWait;
         StWait: begin
            // Completion takes priority over a simultaneous timeout.
            if (stable_hit) begin
               state_d = range_bad ? StFail : StDone;
            end else if (timeout_hit) begin
               state_d = StFail;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cpu_clr   = (state_q == StClear);
      cpu_start = (state_q == StLaunch);
      busy      = (state_q == StClear) || (state_q == StLaunch) || (state_q == StWait);
      cpu_a     = cpu_a_q;
      cpu_b     = cpu_b_q;
      done      = done_q;
      err       = err_q;
      result    = result_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt_q  <= '0;
         wait_cnt_q <= '0;
         stab_cnt_q <= '0;
         prev_q     <= '0;
         cpu_a_q    <= '0;
         cpu_b_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= ERR_NONE;
         result_q   <= '0;
      end else begin
         case (state_q)
            StIdle, StDone, StFail: begin
               if (accept) begin
                  done_q <= 1'b0;
                  if (ops_bad) begin
                     err_q <= ERR_OPERAND;
                  end else begin
                     cpu_a_q   <= {25'd0, op_a};
                     cpu_b_q   <= {25'd0, op_b};
                     err_q     <= ERR_NONE;
                     result_q  <= '0;
                     clr_cnt_q <= '0;
                  end
               end
            end
            StClear: clr_cnt_q <= clr_cnt_q + 4'd1;
            StLaunch: begin
               wait_cnt_q <= '0;
               stab_cnt_q <= '0;
               prev_q     <= '0;
            end
            StWait: begin
               wait_cnt_q <= wait_cnt_q + 1'b1;
               stab_cnt_q <= stab_cnt_d;
               prev_q     <= cpu_result;
               if (stable_hit) begin
                  if (range_bad) begin
                     err_q <= ERR_TIMEOUT;
                  end else begin
                     done_q   <= 1'b1;
                     result_q <= cpu_result[6:0];
                  end
               end else if (timeout_hit) begin
                  err_q <= ERR_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_run_ctrl.sv
// Directed bench for gcd_run_ctrl: normal run, operand rejection, glitch filter, busy ignore,
// restart, timeout and mid-job reset.
module tb_gcd_run_ctrl;

   logic        clk;
   logic        rst;
   logic        start_req;
   logic [6:0]  op_a;
   logic [6:0]  op_b;
   logic [31:0] cpu_result;
   logic        cpu_clr;
   logic        cpu_start;
   logic [31:0] cpu_a;
   logic [31:0] cpu_b;
   logic        busy;
   logic        done;
   logic [1:0]  err;
   logic [6:0]  result;

   int checks = 0;
   int passed = 0;

   gcd_run_ctrl #(
      .CLR_CYCLES     (4),
      .STABLE_CYCLES  (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_req  (start_req),
      .op_a       (op_a),
      .op_b       (op_b),
      .cpu_result (cpu_result),
      .cpu_clr    (cpu_clr),
      .cpu_start  (cpu_start),
      .cpu_a      (cpu_a),
      .cpu_b      (cpu_b),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .result     (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic start(input logic [6:0] a, input logic [6:0] b);
      op_a = a;
      op_b = b;
      start_req = 1'b1;
      step(1);
      start_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start_req = 1'b0;
      op_a = '0;
      op_b = '0;
      cpu_result = '0;
      step(2);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_clr", cpu_clr, 0);
      chk("rst_start", cpu_start, 0);
      chk("rst_cpu_a", cpu_a, 0);
      chk("rst_result", result, 0);
      rst = 1'b0;
      step(1);

      // Normal run: 12, 18 -> 6
      start(7'd12, 7'd18);
      chk("n_clr1", cpu_clr, 1);
      chk("n_busy1", busy, 1);
      chk("n_cpu_a", cpu_a, 12);
      chk("n_cpu_b", cpu_b, 18);
      chk("n_start_early", cpu_start, 0);
      step(3);
      chk("n_clr4", cpu_clr, 1);
      step(1);
      chk("n_launch", cpu_start, 1);
      chk("n_clr_off", cpu_clr, 0);
      step(1);
      chk("n_start_pulse", cpu_start, 0);
      chk("n_busy_wait", busy, 1);
      step(48);
      cpu_result = 32'd6;
      step(1);
      chk("n_done_early", done, 0);
      step(1);
      chk("n_done", done, 1);
      chk("n_result", result, 6);
      chk("n_err", err, 0);
      chk("n_busy_end", busy, 0);
      step(3);
      chk("n_hold", result, 6);

      // Zero operand rejected
      start(7'd0, 7'd35);
      chk("z_err", err, 1);
      chk("z_done", done, 0);
      chk("z_busy", busy, 0);
      chk("z_clr", cpu_clr, 0);
      chk("z_cpu_a", cpu_a, 12);
      step(3);
      chk("z_start", cpu_start, 0);
      chk("z_busy_later", busy, 0);

      // Out-of-range operand rejected
      start(7'd100, 7'd5);
      chk("r_err", err, 1);
      chk("r_busy", busy, 0);

      // Glitch filter: 5 for one cycle, then 0, then stable 7
      cpu_result = 32'd0;
      start(7'd35, 7'd49);
      chk("g_err_clear", err, 0);
      step(4);
      chk("g_launch", cpu_start, 1);
      step(1);
      cpu_result = 32'd5;
      step(1);
      cpu_result = 32'd0;
      step(1);
      chk("g_no_done_glitch", done, 0);
      cpu_result = 32'd7;
      step(1);
      chk("g_done_early", done, 0);
      step(1);
      chk("g_done", done, 1);
      chk("g_result", result, 7);

      // Busy ignore then restart
      cpu_result = 32'd0;
      start(7'd16, 7'd24);
      step(5);
      start(7'd99, 7'd33);
      chk("b_cpu_a", cpu_a, 16);
      chk("b_cpu_b", cpu_b, 24);
      chk("b_busy", busy, 1);
      chk("b_no_clr", cpu_clr, 0);
      cpu_result = 32'd8;
      step(2);
      chk("b_done", done, 1);
      chk("b_result", result, 8);
      cpu_result = 32'd0;
      start(7'd99, 7'd33);
      chk("s_done_clr", done, 0);
      chk("s_result_clr", result, 0);
      chk("s_cpu_a", cpu_a, 99);
      chk("s_cpu_b", cpu_b, 33);
      step(5);
      cpu_result = 32'd33;
      step(2);
      chk("s_done", done, 1);
      chk("s_result", result, 33);

      // Timeout: 100 cycles after cpu_start
      cpu_result = 32'd0;
      start(7'd10, 7'd20);
      step(4);
      chk("t_launch", cpu_start, 1);
      step(99);
      chk("t_err_early", err, 0);
      chk("t_busy_early", busy, 1);
      step(1);
      chk("t_err", err, 2);
      chk("t_done", done, 0);
      chk("t_busy", busy, 0);

      // Reset mid-WAIT
      start(7'd12, 7'd18);
      step(8);
      chk("m_busy_pre", busy, 1);
      rst = 1'b1;
      #1;
      chk("m_busy", busy, 0);
      chk("m_cpu_a", cpu_a, 0);
      chk("m_err", err, 0);
      chk("m_start", cpu_start, 0);
      step(1);
      rst = 1'b0;
      cpu_result = 32'd6;
      step(5);
      chk("m_no_done", done, 0);
      chk("m_no_busy", busy, 0);
      chk("m_result", result, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/gcd_run_ctrl.md
Name: gcd_run_ctrl

Overview:
Sequencer between the debounced centre-button pulse and the rv32i_cpu GCD program. It validates and latches the two 0-99 operands, clears the CPU, issues one start pulse and watches the CPU result for completion. It then presents a held result with busy/done/error status to the display path. It sits in the Basys3 top between the debounce/operand-entry logic and rv32i_cpu.

Parameters:
CLR_CYCLES, 4, cycles cpu_clr is held asserted before launch (1..15)
STABLE_CYCLES, 2, consecutive identical non-zero cpu_result samples required to declare completion (1..15)
TIMEOUT_CYCLES, 1000000, max WAIT cycles before error (>= 16; counter width = $clog2(TIMEOUT_CYCLES+1))

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-high
start_req  in  1  one-cycle start pulse from debounce
op_a  in  7  operand A, BCD-decoded binary 0-99
op_b  in  7  operand B, binary 0-99
cpu_result  in  32  rv32i_cpu result register (0 = not yet produced)
cpu_clr  out  1  synchronous clear request to CPU, active-high
cpu_start  out  1  one-cycle launch pulse to CPU
cpu_a  out  32  latched operand A, zero-extended
cpu_b  out  32  latched operand B, zero-extended
busy  out  1  job in progress (CLEAR/LAUNCH/WAIT)
done  out  1  result valid and held
err  out  2  00 none, 01 zero/out-of-range operand, 10 timeout
result  out  7  held GCD value, 0-99

Behaviour:
- Reset (async, rst=1): state IDLE; cpu_clr=0, cpu_start=0, cpu_a=cpu_b=0, busy=0, done=0, err=00, result=0; all counters 0. Reset mid-job aborts immediately; no further cpu_start pulse is issued.
- States: IDLE, CLEAR, LAUNCH, WAIT, DONE, FAIL.
- IDLE/DONE/FAIL + start_req: if op_a==0, op_b==0, op_a>99 or op_b>99 -> FAIL next cycle, err=01, done=0, cpu_a/cpu_b unchanged, no cpu_clr/cpu_start. Otherwise latch cpu_a={25'd0,op_a} and cpu_b={25'd0,op_b}, clear done/err/result, go to CLEAR.
- CLEAR: cpu_clr=1 for exactly CLR_CYCLES cycles, busy=1, then LAUNCH.
- LAUNCH: cpu_start=1 for exactly one cycle, cpu_clr=0, then WAIT. Wait and stability counters are cleared.
- WAIT: wait counter increments every cycle. Stability counter increments when cpu_result!=0 and equals the previous sample; otherwise it reloads to 1 if cpu_result!=0, or to 0 if cpu_result==0.
- Completion: stability counter reaches STABLE_CYCLES -> DONE next cycle. result=cpu_result[6:0], done=1, busy=0.
- Range check on completion: if cpu_result > 99 -> FAIL with err=10.
- Timeout: wait counter reaches TIMEOUT_CYCLES without completion -> FAIL, err=10, busy=0.
- Same-cycle conflict: if completion and timeout occur in the same cycle, completion wins.
- start_req while busy=1 is ignored (not queued).
- DONE/FAIL hold all outputs until the next accepted start_req or reset.
- Operand changes: op_a/op_b changes after latching have no effect on cpu_a/cpu_b until the next accepted start.
- Latency, valid start to cpu_start: 1 + CLR_CYCLES cycles.
- Latency, first stable non-zero sample to done=1: STABLE_CYCLES cycles.

Test Plan:
- Normal run: op_a=12, op_b=18, start_req; CPU model returns 6 after 50 cycles -> cpu_clr high for 4 cycles, one cpu_start pulse 5 cycles after start, cpu_a=12, cpu_b=18, done=1, result=6, err=00, busy=0.
- Zero operand: op_a=0, op_b=35, start_req -> FAIL next cycle, err=01, no cpu_clr/cpu_start activity, busy never asserted.
- Timeout: TIMEOUT_CYCLES=100, cpu_result stuck at 0 -> err=10 exactly 100 cycles after cpu_start, done=0, busy=0.
- Glitch filter: cpu_result pulses 5 for one cycle, then 0, then 7 stable -> done=1 only on 7, result=7.
- Busy ignore plus restart: second start_req during WAIT with op_a=99 changes nothing. After DONE, start_req with op_a=99, op_b=33 -> done clears, new job, result=33.
- Reset mid-WAIT: rst pulsed -> all outputs 0 immediately, state IDLE, a later cpu_result change causes no done.
